// File: rtl/inst_queue_if.sv
// Fetch/decode-facing bundle for inst_queue. The fetch side writes with fetch_valid/fetch_instr*/fetch_pc*,
// decode reads slots A/B and pops with dec_pop.
interface inst_queue_if #(
   parameter int AW = 3
);
   // Handshake: a fetch push (fetch_valid 2'b01 or 2'b11) transfers at the rising edge only
   // while fetch_ready=1, otherwise fetch holds its data; a dec_pop bit transfers only for a
   // slot whose out_valid is 1, and 2'b10 on either request field is ignored.
   logic        flush;
   logic [1:0]  fetch_valid;
   logic [31:0] fetch_instr0;
   logic [31:0] fetch_instr1;
   logic [31:0] fetch_pc0;
   logic [31:0] fetch_pc1;
   logic        fetch_ready;
   logic [1:0]  dec_pop;
   logic        out_valid_A;
   logic        out_valid_B;
   logic [31:0] out_instr_A;
   logic [31:0] out_instr_B;
   logic [31:0] out_pc_A;
   logic [31:0] out_pc_B;
   logic [6:0]  opcode_A;
   logic [6:0]  opcode_B;
   logic [2:0]  funct3_A;
   logic [2:0]  funct3_B;
   logic [6:0]  funct7_A;
   logic [6:0]  funct7_B;
   logic [AW:0] count;

   modport master (
      output flush, fetch_valid, fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1, dec_pop,
      input  fetch_ready, out_valid_A, out_valid_B, out_instr_A, out_instr_B, out_pc_A, out_pc_B,
      input  opcode_A, opcode_B, funct3_A, funct3_B, funct7_A, funct7_B, count
   );

   modport slave (
      input  flush, fetch_valid, fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1, dec_pop,
      output fetch_ready, out_valid_A, out_valid_B, out_instr_A, out_instr_B, out_pc_A, out_pc_B,
      output opcode_A, opcode_B, funct3_A, funct3_B, funct7_A, funct7_B, count
   );
endinterface

// File: rtl/inst_queue.sv
// Two-in/two-out circular instruction buffer between fetch and decode, flushed on redirect.
// Define INST_QUEUE_BYPASS_EN to forward fetch straight to the output slots when the queue is empty.
module inst_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input logic        clk,
   input logic        rst,
   inst_queue_if.slave bus
);
   logic [31:0] instr_mem [DEPTH];
   logic [31:0] pc_mem    [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count_q;

   logic [AW-1:0] rd_ptr1;
   logic [AW-1:0] wr_ptr1;
   logic          ready;
   logic          st_va;
   logic          st_vb;
   logic          va;
   logic          vb;
   logic          bypass;
   logic [31:0]   ia;
   logic [31:0]   pa;
   logic [31:0]   ib;
   logic [31:0]   pb;
   logic [1:0]    n_push;
   logic [1:0]    n_pop;
   logic [1:0]    skip;
   logic [1:0]    n_wr;
   logic [1:0]    rd_adv;
   logic [31:0]   w_instr0;
   logic [31:0]   w_pc0;

   assign rd_ptr1 = rd_ptr + AW'(1);
   assign wr_ptr1 = wr_ptr + AW'(1);

   // Ready looks only at the registered count, so a same-cycle pop never reaches it.
   assign ready = (count_q <= (AW+1)'(DEPTH - 2));
   assign st_va = (count_q >= (AW+1)'(1));
   assign st_vb = (count_q >= (AW+1)'(2));

   always_comb begin
      n_push = 2'd0;
      if (ready) begin
         case (bus.fetch_valid)
            2'b01:   n_push = 2'd1;
            2'b11:   n_push = 2'd2;
            default: n_push = 2'd0;
         endcase
      end
   end

   // Slot selection; invalid slots read as all-zero so decode falls into its default branch.
   always_comb begin
      bypass = 1'b0;
      va     = st_va;
      vb     = st_vb;
      ia     = st_va ? instr_mem[rd_ptr]  : 32'h0;
      pa     = st_va ? pc_mem[rd_ptr]     : 32'h0;
      ib     = st_vb ? instr_mem[rd_ptr1] : 32'h0;
      pb     = st_vb ? pc_mem[rd_ptr1]    : 32'h0;
`ifdef INST_QUEUE_BYPASS_EN
      if ((count_q == '0) && !bus.flush) begin
         bypass = 1'b1;
         va     = bus.fetch_valid[0];
         vb     = (bus.fetch_valid == 2'b11);
         ia     = va ? bus.fetch_instr0 : 32'h0;
         pa     = va ? bus.fetch_pc0    : 32'h0;
         ib     = vb ? bus.fetch_instr1 : 32'h0;
         pb     = vb ? bus.fetch_pc1    : 32'h0;
      end
`endif
   end

   always_comb begin
      case (bus.dec_pop)
         2'b01:   n_pop = {1'b0, va};
         2'b11:   n_pop = {1'b0, va} + {1'b0, vb};
         default: n_pop = 2'd0;
      endcase
   end

   // A bypassed pop consumes fetch data directly: those entries are skipped on write and
   // the read pointer stays put, because it already equals the write pointer.
   always_comb begin
      skip     = bypass ? n_pop : 2'd0;
      n_wr     = n_push - skip;
      rd_adv   = bypass ? 2'd0 : n_pop;
      w_instr0 = (skip == 2'd0) ? bus.fetch_instr0 : bus.fetch_instr1;
      w_pc0    = (skip == 2'd0) ? bus.fetch_pc0    : bus.fetch_pc1;
   end

   always_ff @(posedge clk) begin
      if (!bus.flush) begin
         if (n_wr != 2'd0) begin
            instr_mem[wr_ptr] <= w_instr0;
            pc_mem[wr_ptr]    <= w_pc0;
         end
         if (n_wr == 2'd2) begin
            instr_mem[wr_ptr1] <= bus.fetch_instr1;
            pc_mem[wr_ptr1]    <= bus.fetch_pc1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         rd_ptr  <= rd_ptr + AW'(rd_adv);
         wr_ptr  <= wr_ptr + AW'(n_wr);
         count_q <= count_q + (AW+1)'(n_push) - (AW+1)'(n_pop);
      end
   end

   assign bus.fetch_ready = ready;
   assign bus.count       = count_q;
   assign bus.out_valid_A = va;
   assign bus.out_valid_B = vb;
   assign bus.out_instr_A = ia;
   assign bus.out_instr_B = ib;
   assign bus.out_pc_A    = pa;
   assign bus.out_pc_B    = pb;
   assign bus.opcode_A    = ia[6:0];
   assign bus.opcode_B    = ib[6:0];
   assign bus.funct3_A    = ia[14:12];
   assign bus.funct3_B    = ib[14:12];
   assign bus.funct7_A    = ia[31:25];
   assign bus.funct7_B    = ib[31:25];
endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a reference queue of {instr, pc} tracks every accepted push and pop.
module tb_inst_queue;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk = 1'b0;
   logic rst;

   inst_queue_if #(.AW(AW)) bus();
   inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int last_push = 0;
   logic [31:0] next_pc = 32'h0;
   logic [63:0] exp_q[$];

   task automatic idle_inputs();
      bus.flush        = 1'b0;
      bus.fetch_valid  = 2'b00;
      bus.dec_pop      = 2'b00;
      bus.fetch_instr0 = 32'h0;
      bus.fetch_instr1 = 32'h0;
      bus.fetch_pc0    = 32'h0;
      bus.fetch_pc1    = 32'h0;
   endtask

   // Drive one cycle, update the reference queue at the edge, then return to idle inputs.
   task automatic step(input logic [1:0] fv, input logic [1:0] pop, input logic fl,
                       input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
      int sz;
      int np;
      int npop;
      logic va;
      logic vb;
      bus.fetch_valid  = fv;
      bus.dec_pop      = pop;
      bus.flush        = fl;
      bus.fetch_instr0 = i0;
      bus.fetch_pc0    = p0;
      bus.fetch_instr1 = i1;
      bus.fetch_pc1    = p1;
      sz = exp_q.size();
      np = 0;
      if (sz <= DEPTH - 2) np = (fv == 2'b01) ? 1 : (fv == 2'b11) ? 2 : 0;
      va = (sz >= 1);
      vb = (sz >= 2);
`ifdef INST_QUEUE_BYPASS_EN
      if (sz == 0 && !fl) begin
         va = fv[0];
         vb = (fv == 2'b11);
      end
`endif
      npop = (pop == 2'b01) ? int'(va) : (pop == 2'b11) ? int'(va) + int'(vb) : 0;
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
         last_push = 0;
      end else begin
         if (np >= 1) exp_q.push_back({i0, p0});
         if (np == 2) exp_q.push_back({i1, p1});
         for (int k = 0; k < npop; k++) exp_q.delete(0);
         last_push = np;
      end
      #1;
      idle_inputs();
   endtask

   task automatic auto_step(input logic [1:0] fv, input logic [1:0] pop, input logic fl);
      step(fv, pop, fl, $urandom, next_pc, $urandom, next_pc + 32'd4);
      next_pc = next_pc + 32'(4 * last_push);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      total++; if (bus.out_valid_A !== 1'b0 || bus.out_valid_B !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b exp=00", bus.out_valid_A, bus.out_valid_B); end
      total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.fetch_ready); end
      total++; if (bus.out_instr_A !== 32'h0 || bus.out_pc_B !== 32'h0 || bus.opcode_A !== 7'h0) begin bad++; $display("FAIL reset_data instrA=%h pcB=%h opA=%h exp=0", bus.out_instr_A, bus.out_pc_B, bus.opcode_A); end
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_basic();
      step(2'b11, 2'b00, 1'b0, 32'h00500093, 32'h0, 32'h00A00113, 32'h4);
      next_pc = 32'h8;
      total++; if (bus.out_valid_A !== 1'b1 || bus.out_valid_B !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b%b exp=11", bus.out_valid_A, bus.out_valid_B); end
      total++; if (bus.opcode_A !== 7'h13) begin bad++; $display("FAIL basic_opcodeA got=%h exp=13", bus.opcode_A); end
      total++; if (bus.funct3_A !== 3'h0) begin bad++; $display("FAIL basic_funct3A got=%h exp=0", bus.funct3_A); end
      total++; if (bus.out_pc_B !== 32'h4) begin bad++; $display("FAIL basic_pcB got=%h exp=4", bus.out_pc_B); end
      total++; if (bus.count !== 4'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", bus.count); end
      total++; if (bus.out_instr_A !== 32'h00500093 || bus.out_instr_B !== 32'h00A00113) begin bad++; $display("FAIL basic_instr got=%h/%h exp=00500093/00a00113", bus.out_instr_A, bus.out_instr_B); end
      auto_step(2'b00, 2'b11, 1'b0);
      total++; if (bus.count !== 4'd0 || bus.out_valid_A !== 1'b0) begin bad++; $display("FAIL basic_drain count=%0d validA=%b exp=0/0", bus.count, bus.out_valid_A); end
   endtask

   task automatic test_fill();
      logic [63:0] ea;
      logic [63:0] eb;
      auto_step(2'b00, 2'b00, 1'b1);
      for (int i = 0; i < 6; i++) begin
         total++; if (bus.count !== 4'(exp_q.size())) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, exp_q.size()); end
         total++; if (bus.fetch_ready !== (exp_q.size() <= DEPTH - 2)) begin bad++; $display("FAIL fill_ready got=%b count=%0d", bus.fetch_ready, exp_q.size()); end
         auto_step(2'b11, 2'b00, 1'b0);
      end
      total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL fill_full got=%0d exp=8", bus.count); end
      total++; if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_full got=%b exp=0", bus.fetch_ready); end
      for (int i = 0; i < 4; i++) begin
         ea = exp_q[0];
         eb = exp_q[1];
         total++; if (bus.out_pc_A !== ea[31:0] || bus.out_instr_A !== ea[63:32]) begin bad++; $display("FAIL fill_drainA got=%h/%h exp=%h/%h", bus.out_pc_A, bus.out_instr_A, ea[31:0], ea[63:32]); end
         total++; if (bus.out_pc_B !== eb[31:0] || bus.funct7_B !== eb[63:57]) begin bad++; $display("FAIL fill_drainB got=%h/%h exp=%h/%h", bus.out_pc_B, bus.funct7_B, eb[31:0], eb[63:57]); end
         auto_step(2'b00, 2'b11, 1'b0);
      end
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL fill_empty got=%0d exp=0", bus.count); end
   endtask

   task automatic test_wrap();
      logic [63:0] ea;
      logic [63:0] eb;
      auto_step(2'b00, 2'b00, 1'b1);
      auto_step(2'b01, 2'b00, 1'b0);
      auto_step(2'b11, 2'b11, 1'b0);
      auto_step(2'b11, 2'b11, 1'b0);
      auto_step(2'b11, 2'b11, 1'b0);
      for (int i = 0; i < 10; i++) begin
         ea = exp_q[0];
         eb = exp_q[1];
         total++; if (bus.count !== 4'd2) begin bad++; $display("FAIL wrap_count cyc=%0d got=%0d exp=2", i, bus.count); end
         total++; if (bus.out_pc_A !== ea[31:0] || bus.out_pc_B !== eb[31:0]) begin bad++; $display("FAIL wrap_order cyc=%0d got=%h/%h exp=%h/%h", i, bus.out_pc_A, bus.out_pc_B, ea[31:0], eb[31:0]); end
         total++; if (bus.out_instr_A !== ea[63:32] || bus.out_instr_B !== eb[63:32]) begin bad++; $display("FAIL wrap_instr cyc=%0d got=%h/%h exp=%h/%h", i, bus.out_instr_A, bus.out_instr_B, ea[63:32], eb[63:32]); end
         auto_step(2'b11, 2'b11, 1'b0);
      end
   endtask

   task automatic test_partial_pop();
      logic [63:0] ea;
      auto_step(2'b00, 2'b01, 1'b0);
      ea = exp_q[0];
      total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL partial_setup got=%0d exp=1", bus.count); end
      total++; if (bus.out_valid_B !== 1'b0 || bus.out_instr_B !== 32'h0) begin bad++; $display("FAIL partial_B_before valid=%b instr=%h exp=0/0", bus.out_valid_B, bus.out_instr_B); end
      total++; if (bus.out_pc_A !== ea[31:0]) begin bad++; $display("FAIL partial_A got=%h exp=%h", bus.out_pc_A, ea[31:0]); end
      auto_step(2'b00, 2'b11, 1'b0);
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL partial_count got=%0d exp=0", bus.count); end
      total++; if (bus.out_valid_B !== 1'b0 || bus.out_instr_B !== 32'h0 || bus.out_valid_A !== 1'b0) begin bad++; $display("FAIL partial_after validA=%b validB=%b instrB=%h exp=0", bus.out_valid_A, bus.out_valid_B, bus.out_instr_B); end
   endtask

   task automatic test_illegal();
      logic [63:0] ea;
      auto_step(2'b10, 2'b00, 1'b0);
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL illegal_push got=%0d exp=0", bus.count); end
      auto_step(2'b11, 2'b00, 1'b0);
      auto_step(2'b00, 2'b10, 1'b0);
      ea = exp_q[0];
      total++; if (bus.count !== 4'd2) begin bad++; $display("FAIL illegal_pop got=%0d exp=2", bus.count); end
      total++; if (bus.out_pc_A !== ea[31:0]) begin bad++; $display("FAIL illegal_headA got=%h exp=%h", bus.out_pc_A, ea[31:0]); end
   endtask

   task automatic test_flush();
      auto_step(2'b01, 2'b00, 1'b0);
      auto_step(2'b11, 2'b00, 1'b0);
      total++; if (bus.count !== 4'd5) begin bad++; $display("FAIL flush_setup got=%0d exp=5", bus.count); end
      auto_step(2'b11, 2'b01, 1'b1);
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
      total++; if (bus.out_valid_A !== 1'b0 || bus.opcode_A !== 7'h0) begin bad++; $display("FAIL flush_slotA valid=%b opcode=%h exp=0/0", bus.out_valid_A, bus.opcode_A); end
      total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.fetch_ready); end
   endtask

   task automatic test_async_reset();
      auto_step(2'b11, 2'b00, 1'b0);
      auto_step(2'b11, 2'b00, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", bus.count); end
      total++; if (bus.out_valid_A !== 1'b0 || bus.out_instr_A !== 32'h0 || bus.out_pc_A !== 32'h0) begin bad++; $display("FAIL areset_slotA valid=%b instr=%h pc=%h exp=0", bus.out_valid_A, bus.out_instr_A, bus.out_pc_A); end
      total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b exp=1", bus.fetch_ready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_bypass();
      logic [31:0] i0;
      logic [31:0] i1;
      logic [63:0] ea;
      i0 = 32'h00300193;
      i1 = 32'h40208233;
      auto_step(2'b00, 2'b00, 1'b1);
      bus.fetch_valid  = 2'b11;
      bus.dec_pop      = 2'b01;
      bus.fetch_instr0 = i0;
      bus.fetch_pc0    = next_pc;
      bus.fetch_instr1 = i1;
      bus.fetch_pc1    = next_pc + 32'd4;
      #2;
`ifdef INST_QUEUE_BYPASS_EN
      total++; if (bus.out_valid_A !== 1'b1 || bus.out_instr_A !== i0) begin bad++; $display("FAIL bypass_same valid=%b instr=%h exp=1/%h", bus.out_valid_A, bus.out_instr_A, i0); end
`else
      total++; if (bus.out_valid_A !== 1'b0 || bus.out_instr_A !== 32'h0) begin bad++; $display("FAIL nobypass_same valid=%b instr=%h exp=0/0", bus.out_valid_A, bus.out_instr_A); end
`endif
      step(2'b11, 2'b01, 1'b0, i0, next_pc, i1, next_pc + 32'd4);
      next_pc = next_pc + 32'h8;
      ea = exp_q[0];
`ifdef INST_QUEUE_BYPASS_EN
      total++; if (bus.count !== 4'd1 || bus.out_instr_A !== i1) begin bad++; $display("FAIL bypass_next count=%0d instr=%h exp=1/%h", bus.count, bus.out_instr_A, i1); end
`else
      total++; if (bus.count !== 4'd2 || bus.out_instr_A !== i0) begin bad++; $display("FAIL nobypass_next count=%0d instr=%h exp=2/%h", bus.count, bus.out_instr_A, i0); end
`endif
      total++; if (bus.out_pc_A !== ea[31:0]) begin bad++; $display("FAIL bypass_headA got=%h exp=%h", bus.out_pc_A, ea[31:0]); end
   endtask

   task automatic test_random();
      logic [63:0] ea;
      logic [63:0] eb;
      logic [1:0]  fv;
      logic [1:0]  pop;
      for (int i = 0; i < 300; i++) begin
         ea = (exp_q.size() >= 1) ? exp_q[0] : 64'h0;
         eb = (exp_q.size() >= 2) ? exp_q[1] : 64'h0;
         total++; if (bus.count !== 4'(exp_q.size())) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, bus.count, exp_q.size()); end
         total++; if (bus.fetch_ready !== (exp_q.size() <= DEPTH - 2)) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b", i, bus.fetch_ready); end
         total++; if (bus.out_valid_A !== (exp_q.size() >= 1) || bus.out_valid_B !== (exp_q.size() >= 2)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b%b size=%0d", i, bus.out_valid_A, bus.out_valid_B, exp_q.size()); end
         total++; if ({bus.out_instr_A, bus.out_pc_A} !== ea) begin bad++; $display("FAIL rand_slotA cyc=%0d got=%h%h exp=%h", i, bus.out_instr_A, bus.out_pc_A, ea); end
         total++; if ({bus.out_instr_B, bus.out_pc_B} !== eb) begin bad++; $display("FAIL rand_slotB cyc=%0d got=%h%h exp=%h", i, bus.out_instr_B, bus.out_pc_B, eb); end
         total++; if (bus.opcode_B !== eb[38:32] || bus.funct3_A !== ea[46:44] || bus.funct7_A !== ea[63:57]) begin bad++; $display("FAIL rand_fields cyc=%0d opB=%h f3A=%h f7A=%h", i, bus.opcode_B, bus.funct3_A, bus.funct7_A); end
         case ($urandom_range(0, 3))
            0:       fv = 2'b00;
            1:       fv = 2'b01;
            2:       fv = 2'b11;
            default: fv = 2'b10;
         endcase
         case ($urandom_range(0, 3))
            0:       pop = 2'b00;
            1:       pop = 2'b01;
            2:       pop = 2'b11;
            default: pop = 2'b10;
         endcase
         auto_step(fv, pop, ($urandom_range(0, 19) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_wrap();
      test_partial_pop();
      test_illegal();
      test_flush();
      test_async_reset();
      test_bypass();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
